bmem_arbiter: RTL
=================

# bmem_arbiter

Two-port arbiter and burst sequencer between the instruction cache, the data cache and the 64-bit burst memory (bmem). It grants one cache line request at a time, with round-robin priority. It issues the bmem read command or the four-beat write burst, and assembles the four returned read beats into a 256-bit line. It returns that line to the granted cache with a single-cycle response.

## Interface
- LINE_BITS, 256, cache line width
- BEAT_BITS, 64, bmem beat width; BEATS = LINE_BITS/BEAT_BITS = 4 (only 4 is supported)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- icache_dfp_addr  in  32  icache line request address
- icache_dfp_read  in  1  icache read request, held until response
- icache_dfp_rdata  out  256  line returned to icache
- icache_dfp_resp  out  1  icache response pulse
- dcache_dfp_addr  in  32  dcache line request address
- dcache_dfp_read  in  1  dcache read request, held until response
- dcache_dfp_write  in  1  dcache writeback request, held until response
- dcache_dfp_wdata  in  256  dcache writeback line
- dcache_dfp_rdata  out  256  line returned to dcache
- dcache_dfp_resp  out  1  dcache response pulse
- bmem_addr  out  32  burst address, 32-byte aligned
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  bmem accepts command/beat this cycle
- bmem_raddr  in  32  address tag of returning read beat
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR, RESP.
- IDLE:
  - Sample requests.
  - Dcache write and read both high: treated as write.
  - Both caches requesting: grant the port not granted last. last_grant resets to icache, so dcache wins the first tie.
  - On grant, capture: port, op, line address {addr[31:5],5'b0} and, for writes, dcache_dfp_wdata.
  - Next state is RD_REQ for a read, WR for a write.
- RD_REQ:
  - Drive bmem_read=1 and bmem_addr = captured address.
  - Hold until bmem_ready=1, then go to RD_DATA.
- RD_DATA:
  - Accept a beat when bmem_rvalid=1 and bmem_raddr equals the captured address.
  - Write the beat into line slice beat_cnt*64 +: 64, then increment beat_cnt.
  - Beats whose bmem_raddr mismatches are ignored.
  - After the 4th beat, go to RESP.
- WR:
  - Drive bmem_write=1, bmem_addr = captured address, bmem_wdata = captured line slice beat_cnt*64 +: 64.
  - Increment beat_cnt on cycles with bmem_ready=1.
  - After beat 3 is accepted, go to RESP.
- RESP:
  - Pulse the granted port's dfp_resp for 1 cycle; the other port's resp stays 0.
  - Read: drive the assembled line on that port's dfp_rdata.
  - Update last_grant; next state IDLE.
- dfp_rdata holds its last value until the next read response to that port.
- Write responses do not change dcache_dfp_rdata.
- bmem_rvalid outside RD_DATA is ignored.
- Requests arriving while busy are held by the cache and sampled on return to IDLE.
- beat_cnt is 2 bits and wraps to 0 on the last beat.

## Timing
- Reset values: all outputs 0; state IDLE; beat_cnt 0; last_grant icache; captured line 0.
- Reset mid-burst: abort immediately and return to IDLE. No response is issued for the aborted request, and beats still in flight are ignored.
- Read latency: grant at IDLE edge → bmem_read in the next cycle → resp one cycle after the 4th accepted beat.
- Write, with bmem_ready held high: 6 cycles from grant to resp (IDLE, WR×4, RESP).
- bmem_read is high for exactly one accepted cycle per read.
- bmem_write is high for exactly 4 accepted beats per write; bmem_addr is constant across them.
- bmem_ready low stalls RD_REQ and WR without advancing beat_cnt. bmem_wdata holds its value during the stall.
- Requester must drop read/write in the cycle after its dfp_resp. Requests are resampled in the IDLE cycle that follows RESP.

## Structure
- Package bmem_arb_pkg:
  - state enum: IDLE, RD_REQ, RD_DATA, WR, RESP
  - port enum: PORT_I, PORT_D
  - LINE_BITS, BEAT_BITS, BEATS, OFFSET_BITS=5
- Sub-module line_buffer:
  - 256-bit register with beat-indexed load (beat data in, 2-bit index, enable) and a full-line load.
  - Beat-indexed read mux for write beats.
  - The arbiter FSM instantiates it once.

## Test plan
- Icache read 0x0000_1234, bmem returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → bmem_addr=0x0000_1220; icache_dfp_rdata={0x44..,0x33..,0x22..,0x11..}; 1-cycle icache_dfp_resp; dcache_dfp_resp=0.
- Dcache write 0x8000_0040, wdata beats A,B,C,D, bmem_ready low on the 2nd beat for 2 cycles → bmem_wdata sequence A,B,B,B,C,D with bmem_write high throughout; resp one cycle after D is accepted.
- Both caches request in the same cycle after reset → dcache served first, icache second. Repeating the tie alternates the grant.
- Read in RD_DATA with an interleaved beat tagged 0xDEAD_0000 → that beat is ignored; the line contains only matching beats.
- rst asserted after 2 read beats, then a new icache read → bmem_read reissued, 4 fresh beats required, no spurious resp.
- Dcache read and write both high → write burst issued, no bmem_read.

Source files
------------

// File: rtl/bmem_arb_pkg.sv
// rtl/bmem_arb_pkg.sv - shared types, sizes and address helper for the bmem arbiter
package bmem_arb_pkg;

  localparam int LINE_BITS     = 256;
  localparam int BEAT_BITS     = 64;
  localparam int BEATS         = LINE_BITS / BEAT_BITS;
  localparam int OFFSET_BITS   = 5;
  localparam int BEAT_IDX_BITS = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR,
    RESP
  } state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

  // Clear the byte-within-line offset so every burst starts on a 32-byte boundary.
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return addr & ~((32'd1 << OFFSET_BITS) - 32'd1);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one cache line of storage with beat-indexed load and read
// Ports:
//   clk, rst              clock, asynchronous active-high reset (clears the line)
//   line_we, line_data    load the whole line (writeback capture)
//   beat_we, beat_data    load one beat at beat_idx (read assembly)
//   beat_idx              beat index used for both beat load and beat read
//   line                  full stored line
//   beat                  stored beat selected by beat_idx (write burst data)
module line_buffer
  import bmem_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     line_we,
  input  logic [LINE_BITS-1:0]     line_data,
  input  logic                     beat_we,
  input  logic [BEAT_IDX_BITS-1:0] beat_idx,
  input  logic [BEAT_BITS-1:0]     beat_data,
  output logic [LINE_BITS-1:0]     line,
  output logic [BEAT_BITS-1:0]     beat
);

  // Beat 0 lives in the least significant 64 bits of the line.
  logic [BEATS-1:0][BEAT_BITS-1:0] line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (line_we) begin
      line_q <= line_data;
    end else if (beat_we) begin
      line_q[beat_idx] <= beat_data;
    end
  end

  assign line = line_q;
  assign beat = line_q[beat_idx];

endmodule

// File: rtl/bmem_arbiter.sv
// rtl/bmem_arbiter.sv - round-robin icache/dcache arbiter and 4-beat bmem burst sequencer
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   icache_dfp_*                  icache line read request / line response
//   dcache_dfp_*                  dcache line read or writeback request / line response
//   bmem_addr, bmem_read          read command (one accepted cycle per line)
//   bmem_write, bmem_wdata        writeback beats (four accepted beats per line)
//   bmem_ready                    bmem accepts the command or beat this cycle
//   bmem_raddr/rdata/rvalid       returning read beats, tagged with their line address
module bmem_arbiter
  import bmem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          icache_dfp_addr,
  input  logic                 icache_dfp_read,
  output logic [LINE_BITS-1:0] icache_dfp_rdata,
  output logic                 icache_dfp_resp,
  input  logic [31:0]          dcache_dfp_addr,
  input  logic                 dcache_dfp_read,
  input  logic                 dcache_dfp_write,
  input  logic [LINE_BITS-1:0] dcache_dfp_wdata,
  output logic [LINE_BITS-1:0] dcache_dfp_rdata,
  output logic                 dcache_dfp_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  state_t                   state_q, state_d;
  port_t                    port_q, last_grant_q, grant_port;
  logic                     op_wr_q, grant_wr, grant_valid, capture;
  logic [31:0]              addr_q, grant_addr;
  logic [BEAT_IDX_BITS-1:0] beat_cnt_q;
  logic [LINE_BITS-1:0]     line, irdata_q, drdata_q;
  logic [BEAT_BITS-1:0]     wr_beat;
  logic                     icache_req, dcache_req, beat_accept, wr_accept;

  assign icache_req = icache_dfp_read;
  assign dcache_req = dcache_dfp_read | dcache_dfp_write;

  // Round-robin: on a tie the port that did not win last time is granted.
  // A dcache request with both read and write high is a writeback.
  always_comb begin
    grant_port = PORT_I;
    if (icache_req && dcache_req) begin
      grant_port = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
    end else if (dcache_req) begin
      grant_port = PORT_D;
    end
    grant_valid = icache_req | dcache_req;
    grant_wr    = (grant_port == PORT_D) && dcache_dfp_write;
    grant_addr  = (grant_port == PORT_D) ? dcache_dfp_addr : icache_dfp_addr;
  end

  // Beats tagged with another line's address belong to someone else; drop them.
  assign beat_accept = (state_q == RD_DATA) && bmem_rvalid && (bmem_raddr == addr_q);
  assign wr_accept   = (state_q == WR) && bmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    capture         = 1'b0;
    bmem_read       = 1'b0;
    bmem_write      = 1'b0;
    bmem_wdata      = '0;
    icache_dfp_resp = 1'b0;
    dcache_dfp_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          capture = 1'b1;
          state_d = grant_wr ? WR : RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        if (bmem_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (beat_accept && (beat_cnt_q == BEAT_IDX_BITS'(BEATS - 1))) state_d = RESP;
      end
      WR: begin
        bmem_write = 1'b1;
        bmem_wdata = wr_beat;
        if (wr_accept && (beat_cnt_q == BEAT_IDX_BITS'(BEATS - 1))) state_d = RESP;
      end
      RESP: begin
        icache_dfp_resp = (port_q == PORT_I);
        dcache_dfp_resp = (port_q == PORT_D);
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // beat_cnt is reloaded on grant and wraps back to 0 on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      port_q       <= PORT_I;
      op_wr_q      <= 1'b0;
      beat_cnt_q   <= '0;
      last_grant_q <= PORT_I;
      irdata_q     <= '0;
      drdata_q     <= '0;
    end else begin
      if (capture) begin
        addr_q     <= line_addr(grant_addr);
        port_q     <= grant_port;
        op_wr_q    <= grant_wr;
        beat_cnt_q <= '0;
      end else if (beat_accept || wr_accept) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (state_q == RESP) begin
        last_grant_q <= port_q;
        if (port_q == PORT_I) irdata_q <= line;
        if (port_q == PORT_D && !op_wr_q) drdata_q <= line;
      end
    end
  end

  // The assembled line is visible during the response cycle itself; the
  // per-port registers then hold it until that port's next read response.
  assign icache_dfp_rdata = (state_q == RESP && port_q == PORT_I) ? line : irdata_q;
  assign dcache_dfp_rdata = (state_q == RESP && port_q == PORT_D && !op_wr_q) ? line : drdata_q;
  assign bmem_addr        = addr_q;

  line_buffer u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .line_we   (capture && grant_wr),
    .line_data (dcache_dfp_wdata),
    .beat_we   (beat_accept),
    .beat_idx  (beat_cnt_q),
    .beat_data (bmem_rdata),
    .line      (line),
    .beat      (wr_beat)
  );

endmodule
